// File: rtl/alk_carry_shift_ctl_pkg.sv
// Shared encodings for the ALP bitslice carry/shift/flag controller.
// Carry-in source, operand size, shift mode and condition-code bit slots.
package alk_pkg;

    localparam logic [1:0] ALK_CIN_ZERO  = 2'b00;
    localparam logic [1:0] ALK_CIN_ONE   = 2'b01;
    localparam logic [1:0] ALK_CIN_SAVE  = 2'b10;
    localparam logic [1:0] ALK_CIN_CFLAG = 2'b11;

    localparam logic [1:0] ALK_SZ_BYTE = 2'b00;
    localparam logic [1:0] ALK_SZ_WORD = 2'b01;
    localparam logic [1:0] ALK_SZ_LONG = 2'b10;

    localparam logic [1:0] ALK_SHF_ZERO  = 2'b00;
    localparam logic [1:0] ALK_SHF_ROT   = 2'b01;
    localparam logic [1:0] ALK_SHF_ARITH = 2'b10;
    localparam logic [1:0] ALK_SHF_LINK  = 2'b11;

    localparam int CC_N = 3;
    localparam int CC_Z = 2;
    localparam int CC_V = 1;
    localparam int CC_C = 0;

    // Pick the byte/word/long variant of a signal; size 1x means long.
    function automatic logic sz_pick(
        input logic [1:0] sz,
        input logic       b,
        input logic       w,
        input logic       l
    );
        logic r;
        r = l;
        if (sz == ALK_SZ_BYTE) r = b;
        if (sz == ALK_SZ_WORD) r = w;
        return r;
    endfunction

endpackage

// File: rtl/alk_carry_shift_ctl_if.sv
// Bitslice-array side bundle: carry lookahead, shift links, flags, counter.
// master = array/sequencer side, slave = alk_carry_shift_ctl.
interface alk_carry_shift_ctl_if #(
    parameter int CNT_W = 5
);
    logic [7:0]       p_l;
    logic [7:0]       g_l;
    logic [7:0]       aluc_l;
    logic [1:0]       cin_sel_h;
    logic             cy_save_en_h;
    logic [1:0]       d_size_h;
    logic [1:0]       shf_mode_h;
    logic             shf_dir_h;
    logic             a31_h;
    logic             a_so31_l;
    logic             a_so0_l;
    logic             q_so31_l;
    logic             q_so0_l;
    logic             a_si31_l;
    logic             a_si0_l;
    logic             q_si31_l;
    logic             q_si0_l;
    logic [3:0]       wmuxz_h;
    logic [3:0]       aluv_h;
    logic [2:0]       msb_h;
    logic             cc_en_h;
    logic [3:0]       cc_h;
    logic             cy_save_h;
    logic             cnt_load_h;
    logic [CNT_W-1:0] cnt_val_h;
    logic             cnt_dec_h;
    logic             cnt_zero_h;

    modport master (
        output p_l, g_l, cin_sel_h, cy_save_en_h, d_size_h,
        output shf_mode_h, shf_dir_h, a31_h,
        output a_so31_l, a_so0_l, q_so31_l, q_so0_l,
        output wmuxz_h, aluv_h, msb_h, cc_en_h,
        output cnt_load_h, cnt_val_h, cnt_dec_h,
        input  aluc_l, a_si31_l, a_si0_l, q_si31_l, q_si0_l,
        input  cc_h, cy_save_h, cnt_zero_h
    );

    modport slave (
        input  p_l, g_l, cin_sel_h, cy_save_en_h, d_size_h,
        input  shf_mode_h, shf_dir_h, a31_h,
        input  a_so31_l, a_so0_l, q_so31_l, q_so0_l,
        input  wmuxz_h, aluv_h, msb_h, cc_en_h,
        input  cnt_load_h, cnt_val_h, cnt_dec_h,
        output aluc_l, a_si31_l, a_si0_l, q_si31_l, q_si0_l,
        output cc_h, cy_save_h, cnt_zero_h
    );
endinterface

// File: rtl/alk_cla8.sv
// Eight-nibble carry lookahead over active-low generate/propagate.
// Ports: p_l/g_l nibble P/G (low), c0 carry-in, c[8:0] carries.
module alk_cla8 (
    input  logic [7:0] p_l,
    input  logic [7:0] g_l,
    input  logic       c0,
    output logic [8:0] c
);
    logic cy;

    always_comb begin
        cy   = c0;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < 8; i++) begin
            cy       = ~g_l[i] | (~p_l[i] & cy);
            c[i + 1] = cy;
        end
    end
endmodule

// File: rtl/alk_carry_shift_ctl.sv
// Carry, shift-link, condition-code and iteration-count control for ALP.
// Ports: qdck_l clock, init_l async reset (low), bus array-side bundle.
module alk_carry_shift_ctl
    import alk_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic                 qdck_l,
    input  logic                 init_l,
    alk_carry_shift_ctl_if.slave bus
);
    logic [8:0]       c;
    logic             c0;
    logic             co_sel;
    logic [3:0]       cc_q, cc_d;
    logic             cy_q, cy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saved carry and C flag are taken pre-edge, so no comb loop.
    always_comb begin
        c0 = 1'b0;
        unique case (bus.cin_sel_h)
            ALK_CIN_ZERO:  c0 = 1'b0;
            ALK_CIN_ONE:   c0 = 1'b1;
            ALK_CIN_SAVE:  c0 = cy_q;
            ALK_CIN_CFLAG: c0 = cc_q[CC_C];
            default:       c0 = 1'b0;
        endcase
    end

    alk_cla8 u_cla (
        .p_l (bus.p_l),
        .g_l (bus.g_l),
        .c0  (c0),
        .c   (c)
    );

    assign bus.aluc_l = ~c[7:0];
    assign co_sel     = sz_pick(bus.d_size_h, c[2], c[4], c[8]);

    always_comb begin
        cy_d = cy_q;
        cc_d = cc_q;
        if (bus.cy_save_en_h) cy_d = co_sel;
        if (bus.cc_en_h) begin
            cc_d[CC_N] = sz_pick(bus.d_size_h, bus.msb_h[0],
                                 bus.msb_h[1], bus.msb_h[2]);
            cc_d[CC_Z] = sz_pick(bus.d_size_h, bus.wmuxz_h[0],
                                 &bus.wmuxz_h[1:0], &bus.wmuxz_h);
            cc_d[CC_V] = sz_pick(bus.d_size_h, bus.aluv_h[0],
                                 bus.aluv_h[1], bus.aluv_h[3]);
            cc_d[CC_C] = co_sel;
        end
    end

    // Load wins over decrement; decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.cnt_load_h) begin
            cnt_d = bus.cnt_val_h;
        end else if (bus.cnt_dec_h && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge qdck_l or negedge init_l) begin
        if (!init_l) begin
            cc_q  <= '0;
            cy_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            cc_q  <= cc_d;
            cy_q  <= cy_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.cc_h       = cc_q;
    assign bus.cy_save_h  = cy_q;
    assign bus.cnt_zero_h = (cnt_q == '0);

    // Lines not fed for the current direction idle at 1 (inactive).
    always_comb begin
        bus.a_si31_l = 1'b1;
        bus.a_si0_l  = 1'b1;
        bus.q_si31_l = 1'b1;
        bus.q_si0_l  = 1'b1;
        unique case (bus.shf_mode_h)
            ALK_SHF_ROT: begin
                if (bus.shf_dir_h) begin
                    bus.a_si31_l = bus.a_so0_l;
                    bus.q_si31_l = bus.q_so0_l;
                end else begin
                    bus.a_si0_l = bus.a_so31_l;
                    bus.q_si0_l = bus.q_so31_l;
                end
            end
            ALK_SHF_ARITH: begin
                if (bus.shf_dir_h) bus.a_si31_l = ~bus.a31_h;
            end
            ALK_SHF_LINK: begin
                if (bus.shf_dir_h) begin
                    bus.a_si31_l = ~cy_q;
                    bus.q_si31_l = bus.a_so0_l;
                end else begin
                    bus.a_si0_l = bus.q_so31_l;
                    bus.q_si0_l = ~c[8];
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_alk_carry_shift_ctl.sv
// Directed bench for alk_carry_shift_ctl: vector table plus sequences.
// Expected values are hand-computed constants.
module tb_alk_carry_shift_ctl;

    logic qdck_l = 1'b0;
    logic init_l = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    alk_carry_shift_ctl_if #(.CNT_W(5)) bus ();

    alk_carry_shift_ctl #(.CNT_W(5)) dut (
        .qdck_l (qdck_l),
        .init_l (init_l),
        .bus    (bus)
    );

    always #5 qdck_l = ~qdck_l;

    typedef struct {
        logic [1:0] cin;
        logic [7:0] p_l;
        logic [7:0] g_l;
        logic [1:0] mode;
        logic       dir;
        logic       a31;
        logic [3:0] so;
        logic [7:0] exp_c;
        logic [3:0] exp_si;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge qdck_l);
        #1;
    endtask

    function automatic logic [3:0] si();
        return {bus.a_si31_l, bus.a_si0_l, bus.q_si31_l, bus.q_si0_l};
    endfunction

    initial begin
        vecs[0] = '{2'b00, 8'hFF, 8'hFF, 2'b00, 1'b0, 1'b0,
                    4'b1111, 8'hFF, 4'b1111};
        vecs[1] = '{2'b01, 8'h00, 8'hFF, 2'b01, 1'b0, 1'b0,
                    4'b0111, 8'h00, 4'b1011};
        vecs[2] = '{2'b00, 8'hFF, 8'hFE, 2'b01, 1'b1, 1'b0,
                    4'b1010, 8'hFD, 4'b0101};
        vecs[3] = '{2'b00, 8'hF0, 8'hFE, 2'b10, 1'b1, 1'b1,
                    4'b1111, 8'hE1, 4'b0111};
        vecs[4] = '{2'b01, 8'hFF, 8'hFF, 2'b10, 1'b0, 1'b1,
                    4'b1111, 8'hFE, 4'b1111};
        vecs[5] = '{2'b00, 8'hFF, 8'h7F, 2'b11, 1'b0, 1'b0,
                    4'b1101, 8'hFF, 4'b1010};
        vecs[6] = '{2'b01, 8'hFE, 8'hFD, 2'b11, 1'b1, 1'b0,
                    4'b1011, 8'hF8, 4'b1101};
        vecs[7] = '{2'b00, 8'h00, 8'hFF, 2'b00, 1'b1, 1'b0,
                    4'b0000, 8'hFF, 4'b1111};
        vecs[8] = '{2'b01, 8'h00, 8'hFF, 2'b10, 1'b1, 1'b0,
                    4'b0000, 8'h00, 4'b1111};

        bus.p_l          = 8'hFF;
        bus.g_l          = 8'hFF;
        bus.cin_sel_h    = 2'b00;
        bus.cy_save_en_h = 1'b0;
        bus.d_size_h     = 2'b10;
        bus.shf_mode_h   = 2'b00;
        bus.shf_dir_h    = 1'b0;
        bus.a31_h        = 1'b0;
        bus.a_so31_l     = 1'b1;
        bus.a_so0_l      = 1'b1;
        bus.q_so31_l     = 1'b1;
        bus.q_so0_l      = 1'b1;
        bus.wmuxz_h      = 4'h0;
        bus.aluv_h       = 4'h0;
        bus.msb_h        = 3'b000;
        bus.cc_en_h      = 1'b0;
        bus.cnt_load_h   = 1'b0;
        bus.cnt_val_h    = 5'd0;
        bus.cnt_dec_h    = 1'b0;

        #3;
        chk("rst_cc", 32'(bus.cc_h), 32'h0);
        chk("rst_cy", 32'(bus.cy_save_h), 32'h0);
        chk("rst_zero", 32'(bus.cnt_zero_h), 32'h1);
        #4 init_l = 1'b1;
        step();

        for (int i = 0; i < 9; i++) begin
            bus.cin_sel_h  = vecs[i].cin;
            bus.p_l        = vecs[i].p_l;
            bus.g_l        = vecs[i].g_l;
            bus.shf_mode_h = vecs[i].mode;
            bus.shf_dir_h  = vecs[i].dir;
            bus.a31_h      = vecs[i].a31;
            {bus.a_so31_l, bus.a_so0_l,
             bus.q_so31_l, bus.q_so0_l} = vecs[i].so;
            #1;
            chk($sformatf("vec%0d_aluc", i), 32'(bus.aluc_l),
                32'(vecs[i].exp_c));
            chk($sformatf("vec%0d_si", i), 32'(si()),
                32'(vecs[i].exp_si));
        end
        bus.shf_mode_h = 2'b00;
        {bus.a_so31_l, bus.a_so0_l, bus.q_so31_l, bus.q_so0_l} = 4'hF;

        // carry ripple and size-selected saved carry
        bus.cin_sel_h    = 2'b01;
        bus.p_l          = 8'h00;
        bus.g_l          = 8'hFF;
        bus.d_size_h     = 2'b10;
        bus.cy_save_en_h = 1'b1;
        #1 chk("ripple_aluc", 32'(bus.aluc_l), 32'h00);
        step();
        chk("ripple_cy_long", 32'(bus.cy_save_h), 32'h1);
        bus.cin_sel_h = 2'b00;
        bus.p_l       = 8'hFF;
        step();
        chk("cy_clear", 32'(bus.cy_save_h), 32'h0);
        bus.cin_sel_h = 2'b01;
        bus.p_l       = 8'h00;
        bus.d_size_h  = 2'b00;
        step();
        chk("ripple_cy_byte", 32'(bus.cy_save_h), 32'h1);
        bus.p_l      = 8'hFC;
        bus.d_size_h = 2'b10;
        step();
        chk("p_fc_cy_long", 32'(bus.cy_save_h), 32'h0);
        bus.d_size_h = 2'b00;
        step();
        chk("p_fc_cy_byte", 32'(bus.cy_save_h), 32'h1);
        bus.d_size_h = 2'b01;
        step();
        chk("p_fc_cy_word", 32'(bus.cy_save_h), 32'h0);
        bus.cy_save_en_h = 1'b0;
        step();
        chk("cy_hold", 32'(bus.cy_save_h), 32'h0);

        // multi-precision chaining through the saved carry
        bus.cin_sel_h    = 2'b00;
        bus.p_l          = 8'hFF;
        bus.g_l          = 8'h7F;
        bus.d_size_h     = 2'b10;
        bus.cy_save_en_h = 1'b1;
        step();
        chk("mp_cy", 32'(bus.cy_save_h), 32'h1);
        bus.cy_save_en_h = 1'b0;
        bus.cin_sel_h    = 2'b10;
        bus.g_l          = 8'hFF;
        #1 chk("mp_aluc", 32'(bus.aluc_l), 32'hFE);
        bus.shf_mode_h = 2'b11;
        bus.shf_dir_h  = 1'b1;
        bus.a_so0_l    = 1'b0;
        #1 chk("link_right", 32'(si()), 32'b0101);
        bus.shf_dir_h = 1'b0;
        bus.q_so31_l  = 1'b1;
        #1 chk("link_left", 32'(si()), 32'b1111);
        bus.shf_mode_h = 2'b00;
        bus.a_so0_l    = 1'b1;

        // condition codes
        bus.cin_sel_h = 2'b00;
        bus.d_size_h  = 2'b01;
        bus.msb_h     = 3'b010;
        bus.wmuxz_h   = 4'b0011;
        bus.aluv_h    = 4'b0010;
        bus.cc_en_h   = 1'b1;
        step();
        chk("cc_word", 32'(bus.cc_h), 32'b1110);
        bus.d_size_h = 2'b10;
        bus.msb_h    = 3'b100;
        bus.wmuxz_h  = 4'b1111;
        bus.aluv_h   = 4'b0001;
        bus.g_l      = 8'h7F;
        step();
        chk("cc_long", 32'(bus.cc_h), 32'b1101);
        bus.cc_en_h = 1'b0;
        bus.msb_h   = 3'b000;
        bus.wmuxz_h = 4'b0000;
        bus.g_l     = 8'hFF;
        step();
        chk("cc_hold", 32'(bus.cc_h), 32'b1101);
        bus.cin_sel_h = 2'b11;
        #1 chk("cin_cflag", 32'(bus.aluc_l), 32'hFE);
        bus.cin_sel_h = 2'b00;

        // counter edges
        bus.cnt_load_h = 1'b1;
        bus.cnt_val_h  = 5'd5;
        step();
        chk("cnt_load5", 32'(bus.cnt_zero_h), 32'h0);
        bus.cnt_val_h = 5'd0;
        bus.cnt_dec_h = 1'b1;
        step();
        chk("cnt_load0_dec", 32'(bus.cnt_zero_h), 32'h1);
        bus.cnt_val_h = 5'd31;
        step();
        chk("cnt_load31_dec", 32'(bus.cnt_zero_h), 32'h0);
        bus.cnt_load_h = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            step();
            chk($sformatf("cnt_dec%0d", i), 32'(bus.cnt_zero_h),
                32'(i >= 31));
        end
        bus.cnt_dec_h = 1'b0;

        // async reset in the middle of a count
        bus.cnt_load_h = 1'b1;
        bus.cnt_val_h  = 5'd7;
        step();
        bus.cnt_load_h = 1'b0;
        bus.cnt_dec_h  = 1'b1;
        repeat (3) step();
        bus.cnt_dec_h = 1'b0;
        chk("mid_cnt4", 32'(bus.cnt_zero_h), 32'h0);
        bus.cnt_load_h   = 1'b1;
        bus.cnt_val_h    = 5'd5;
        bus.cc_en_h      = 1'b1;
        bus.cy_save_en_h = 1'b1;
        bus.msb_h        = 3'b111;
        bus.g_l          = 8'h00;
        #2 init_l = 1'b0;
        #1;
        chk("arst_zero", 32'(bus.cnt_zero_h), 32'h1);
        chk("arst_cc", 32'(bus.cc_h), 32'h0);
        chk("arst_cy", 32'(bus.cy_save_h), 32'h0);
        step();
        chk("arst_hold_zero", 32'(bus.cnt_zero_h), 32'h1);
        chk("arst_hold_cc", 32'(bus.cc_h), 32'h0);
        init_l = 1'b1;
        bus.cnt_load_h = 1'b0;
        bus.cc_en_h    = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alk_carry_shift_ctl.md
Name: alk_carry_shift_ctl

Overview:
- Companion control block that sits on the far side of the 32-bit ALP bitslice array's carry, shift-link and flag interfaces.
- Consumes the eight nibble generate/propagate pairs and produces the eight nibble carry-ins.
- Drives the A and Q shifter end-fill inputs from the array's shift-out lines.
- Registers the NZVC condition codes and a saved carry for multi-precision arithmetic.
- Provides a 5-bit iteration counter for multiply and divide step sequences.

Parameters:
CNT_W, 5, width of the iteration counter.

Ports:
qdck_l  in  1  clock; all state updates on its rising edge
init_l  in  1  reset, asynchronous, active-low
p_l  in  8  nibble propagate, active-low
g_l  in  8  nibble generate, active-low
aluc_l  out  8  nibble carry-in, active-low
cin_sel_h  in  2  carry-in source: 00 zero, 01 one, 10 saved carry, 11 C flag
cy_save_en_h  in  1  capture size-selected carry-out into saved carry
d_size_h  in  2  00 byte, 01 word, 1x long
shf_mode_h  in  2  00 zero-fill, 01 rotate, 10 arithmetic, 11 linked A:Q
shf_dir_h  in  1  0 left, 1 right
a31_h  in  1  current A bit 31 (sign)
a_so31_l, a_so0_l, q_so31_l, q_so0_l  in  1 each  array shift-outs
a_si31_l, a_si0_l, q_si31_l, q_si0_l  out  1 each  array shift-ins
wmuxz_h  in  4  per-byte zero
aluv_h  in  4  per-byte overflow
msb_h  in  3  result bits 7, 15, 31
cc_en_h  in  1  load condition codes
cc_h  out  4  registered N,Z,V,C
cy_save_h  out  1  saved carry
cnt_load_h  in  1  load counter
cnt_val_h  in  CNT_W  load value
cnt_dec_h  in  1  decrement counter
cnt_zero_h  out  1  counter == 0

Behaviour:
- Reset values: cc_h=0000, cy_save_h=0, counter=0, cnt_zero_h=1. Reset is asynchronous and overrides all in-flight loads.
- Carry lookahead is combinational, zero latency:
  - g=~g_l, p=~p_l, c0=carry-in source.
  - c[i+1]=g[i] | (p[i] & c[i]).
  - aluc_l[i]=~c[i].
- Size-selected carry-out: byte c2, word c4, long c8.
- Saved carry: when cy_save_en_h, cy_save_h <= size-selected carry-out on the next edge; otherwise it holds.
  - cin_sel_h=10 uses the pre-edge register value, so there is no combinational loop.
- Condition codes: when cc_en_h, on the next edge:
  - N = size-selected msb_h.
  - Z = byte wmuxz_h[0]; word &wmuxz_h[1:0]; long &wmuxz_h.
  - V = aluv_h[0], [1] or [3] by size.
  - C = size-selected carry-out.
  - If cc_en_h and cy_save_en_h are both set, both registers load.
- Shift-ins are combinational. The unused side for the current direction is driven 1 (inactive).
  - Left shifts drive a_si0_l and q_si0_l; right shifts drive a_si31_l and q_si31_l.
  - Mode 00: fill 1 on all driven lines (logic zero).
  - Mode 01: rotate. Left: a_si0_l=a_so31_l, q_si0_l=q_so31_l. Right: a_si31_l=a_so0_l, q_si31_l=q_so0_l.
  - Mode 10: A right fills ~a31_h; A left fills 1; Q behaves as mode 00.
  - Mode 11: right: a_si31_l=~cy_save_h, q_si31_l=a_so0_l. Left: a_si0_l=q_so31_l, q_si0_l=~(long carry-out c8).
- Counter:
  - cnt_load_h has priority over cnt_dec_h.
  - Decrement at 0 saturates at 0, with no wrap to all-ones.
  - cnt_zero_h is registered-state decode and is valid in the same cycle as the count.

Decomposition:
- Package alk_pkg holds:
  - cin_sel encodings ALK_CIN_ZERO/ONE/SAVE/CFLAG.
  - Size encodings ALK_SZ_BYTE/WORD/LONG.
  - Shift-mode encodings ALK_SHF_ZERO/ROT/ARITH/LINK.
  - cc bit indices CC_N/Z/V/C.
- One sub-module, alk_cla8: the 8-nibble lookahead taking p_l, g_l and c0, returning c[8:0].

Test Plan:
- Reset mid-count: load 7, decrement 3 times, assert init_l low between edges -> counter 0, cnt_zero_h=1, cc_h=0000 immediately, before any clock edge.
- Carry ripple: cin_sel=01, p_l=00, g_l=FF, long size, cy_save_en -> aluc_l=00, cy_save_h=1 after the edge; same inputs with byte size -> saved carry from c2 = 1.
- Multi-precision: first cycle g_l=7F (nibble 7 generates), cy_save_en; next cycle cin_sel=10 with p_l=g_l=FF -> aluc_l[0]=0, aluc_l[7:1]=1.
- Flags: word size, msb_h=010, wmuxz_h=0011, aluv_h=0010, cc_en, c4=0 -> cc_h=N1 Z1 V1 C0 = 1110.
- Shifts: mode 10 right with a31_h=1 -> a_si31_l=0, a_si0_l=1. Mode 11 right with a_so0_l=0, cy_save_h=1 -> q_si31_l=0, a_si31_l=0. Mode 01 left with q_so31_l=0 -> q_si0_l=0.
- Counter edges: load 0 with dec asserted -> count 0; load 31 and dec together -> 31; 31 decrements from 31 -> cnt_zero_h=1 exactly on the 31st; a further decrement stays 0.
